// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared widths and encodings for the load/store stage.
package ysyx_22051013_lsu_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned REGADDR_W = 5;
  localparam int unsigned STRB_W    = XLEN / 8;
  localparam int unsigned LANE_W    = 3;

  // funct3 access size/sign encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // writeback select encodings
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/ysyx_22051013_lsu_align.sv
// Byte-lane alignment: store strobe/data shift, load extract/extend, misalign check.
module ysyx_22051013_lsu_align
  import ysyx_22051013_lsu_pkg::*;
(
  input  logic              i_valid,
  input  logic              i_mem_op,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_store_data,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_ldata,
  output logic              o_misalign
);

  logic [5:0]        w_bitsh;
  logic [STRB_W-1:0] w_strb_base;
  logic [XLEN-1:0]   w_rsh;
  logic              w_bad;

  assign w_bitsh = {i_lane, 3'b000};

  // size is funct3[1:0] for both signed and unsigned variants
  always_comb begin
    w_strb_base = 8'hFF;
    w_bad       = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin w_strb_base = 8'h01; w_bad = 1'b0;        end
      2'b01: begin w_strb_base = 8'h03; w_bad = i_lane[0];   end
      2'b10: begin w_strb_base = 8'h0F; w_bad = |i_lane[1:0]; end
      default: begin w_strb_base = 8'hFF; w_bad = |i_lane;   end
    endcase
  end

  assign o_wstrb    = STRB_W'(w_strb_base << i_lane);
  assign o_wdata    = XLEN'(i_store_data << w_bitsh);
  assign o_misalign = i_valid & i_mem_op & w_bad;
  assign w_rsh      = XLEN'(i_rdata >> w_bitsh);

  always_comb begin
    o_ldata = w_rsh;
    case (i_funct3)
      F3_LB:   o_ldata = {{(XLEN-8){w_rsh[7]}}, w_rsh[7:0]};
      F3_LH:   o_ldata = {{(XLEN-16){w_rsh[15]}}, w_rsh[15:0]};
      F3_LW:   o_ldata = {{(XLEN-32){w_rsh[31]}}, w_rsh[31:0]};
      F3_LBU:  o_ldata = {{(XLEN-8){1'b0}}, w_rsh[7:0]};
      F3_LHU:  o_ldata = {{(XLEN-16){1'b0}}, w_rsh[15:0]};
      F3_LWU:  o_ldata = {{(XLEN-32){1'b0}}, w_rsh[31:0]};
      default: o_ldata = w_rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Load/store stage: single-outstanding memory request FSM, load capture and stall.
module ysyx_22051013_lsu
  import ysyx_22051013_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic [INST_W-1:0] ls_inst,
  input  logic [XLEN-1:0]   ls_pc,
  input  logic [XLEN-1:0]   ls_exu_res,
  input  logic [XLEN-1:0]   ls_store_data,
  input  logic              ls_mem_ren,
  input  logic              ls_mem_wen,
  input  logic [2:0]        ls_funct3,
  input  logic [1:0]        ls_wbctl,
  input  logic              ls_hold,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   ls_wbdata,
  output logic [XLEN-1:0]   ls_data_forward,
  output logic              lsu_stall,
  output logic              ls_misalign
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [XLEN-1:0]   r_data;
  logic              w_mem_op;
  logic              w_access;
  logic              w_is_load;
  logic              w_misalign;
  logic [STRB_W-1:0] w_wstrb;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ldata;
  logic              w_unused;

  // instruction and pc are carried by the pipeline register, not consumed here
  assign w_unused = ^{ls_inst, ls_pc};

  assign w_mem_op  = ls_mem_ren | ls_mem_wen;
  assign w_is_load = ls_mem_ren & ~ls_mem_wen;
  assign w_access  = ls_valid & w_mem_op & ~w_misalign;

  ysyx_22051013_lsu_align u_align (
    .i_valid      (ls_valid),
    .i_mem_op     (w_mem_op),
    .i_lane       (ls_exu_res[LANE_W-1:0]),
    .i_funct3     (ls_funct3),
    .i_store_data (ls_store_data),
    .i_rdata      (mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_ldata      (w_ldata),
    .o_misalign   (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // stores complete with zero writeback data
  always_ff @(posedge clk) begin
    if (rst)                                     r_data <= '0;
    else if (r_state == S_WAIT && mem_rsp_valid) r_data <= w_is_load ? w_ldata : '0;
  end

  always_comb begin
    w_state_nxt   = r_state;
    mem_req_valid = 1'b0;
    lsu_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          mem_req_valid = 1'b1;
          lsu_stall     = 1'b1;
          w_state_nxt   = mem_req_ready ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        lsu_stall     = 1'b1;
        if (mem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        if (mem_rsp_valid) w_state_nxt = S_DONE;
      end
      default: begin
        if (!ls_hold) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // request fields read zero whenever no request is being presented
  assign mem_we    = mem_req_valid & ls_mem_wen;
  assign mem_addr  = mem_req_valid ? {ls_exu_res[XLEN-1:3], 3'b000} : '0;
  assign mem_wstrb = (mem_req_valid & ls_mem_wen) ? w_wstrb : '0;
  assign mem_wdata = (mem_req_valid & ls_mem_wen) ? w_wdata : '0;

  assign ls_misalign     = w_misalign;
  assign ls_wbdata       = (r_state == S_DONE) ? r_data : '0;
  assign ls_data_forward = (ls_wbctl == WB_LOAD && r_state == S_DONE) ? ls_wbdata : ls_exu_res;

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Randomized bench for the LSU against a byte-level reference model.
module tb_ysyx_22051013_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid;
  logic [31:0] ls_inst;
  logic [63:0] ls_pc;
  logic [63:0] ls_exu_res;
  logic [63:0] ls_store_data;
  logic        ls_mem_ren;
  logic        ls_mem_wen;
  logic [2:0]  ls_funct3;
  logic [1:0]  ls_wbctl;
  logic        ls_hold;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic [63:0] ls_wbdata;
  logic [63:0] ls_data_forward;
  logic        lsu_stall;
  logic        ls_misalign;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22051013_lsu dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_inst(ls_inst), .ls_pc(ls_pc),
    .ls_exu_res(ls_exu_res), .ls_store_data(ls_store_data), .ls_mem_ren(ls_mem_ren),
    .ls_mem_wen(ls_mem_wen), .ls_funct3(ls_funct3), .ls_wbctl(ls_wbctl), .ls_hold(ls_hold),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .ls_wbdata(ls_wbdata),
    .ls_data_forward(ls_data_forward), .lsu_stall(lsu_stall), .ls_misalign(ls_misalign)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010, 3'b110: return 4;
      default:        return 8;
    endcase
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input int lane, input logic [2:0] f3);
    int n;
    logic [63:0] v, mask;
    n = nbytes(f3);
    v = rd >> (8 * lane);
    if (n == 8) return v;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3, input int lane);
    logic [15:0] s;
    s = ((16'd1 << nbytes(f3)) - 16'd1) << lane;
    return s[7:0];
  endfunction

  function automatic bit m_misalign(input logic [2:0] f3, input logic [63:0] addr);
    return (addr % 64'(nbytes(f3))) != 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ls_valid = 0; ls_mem_ren = 0; ls_mem_wen = 0; ls_hold = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    ls_exu_res = '0; ls_store_data = '0; ls_funct3 = '0; ls_wbctl = '0;
  endtask

  // Runs one instruction: ready after d extra cycles, response after r extra WAIT cycles,
  // DONE held for hold extra cycles. Stray responses are injected outside WAIT.
  task automatic run_txn(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [63:0] rdata, input int d, input int r,
                         input int hold, input logic [63:0] exp_wb);
    logic        store;
    logic [63:0] exp_fwd;
    int          lane;
    store = wen;
    lane  = int'(addr[2:0]);
    ls_valid = 1; ls_mem_ren = ren; ls_mem_wen = wen; ls_funct3 = f3;
    ls_exu_res = addr; ls_store_data = sdata; ls_wbctl = store ? 2'b00 : 2'b01;
    ls_inst = $urandom; ls_pc = {$urandom, $urandom};
    if (m_misalign(f3, addr)) begin
      mem_req_ready = 1; mem_rsp_valid = 0;
      #2;
      chk("mis_flag", 64'(ls_misalign), 64'd1);
      chk("mis_req", 64'(mem_req_valid), 64'd0);
      chk("mis_stall", 64'(lsu_stall), 64'd0);
      chk("mis_wb", ls_wbdata, 64'd0);
      tick();
      idle_inputs();
      return;
    end
    for (int k = 0; k <= d; k++) begin
      mem_req_ready = (k == d);
      mem_rsp_valid = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      #2;
      chk("req_valid", 64'(mem_req_valid), 64'd1);
      chk("req_stall", 64'(lsu_stall), 64'd1);
      chk("req_mis", 64'(ls_misalign), 64'd0);
      chk("req_addr", mem_addr, {addr[63:3], 3'b000});
      chk("req_we", 64'(mem_we), 64'(store));
      if (store) begin
        chk("req_wstrb", 64'(mem_wstrb), 64'(m_strb(f3, lane)));
        chk("req_wdata", mem_wdata, sdata << (8 * lane));
      end
      chk("req_fwd", ls_data_forward, addr);
      tick();
    end
    mem_req_ready = 0;
    for (int k = 0; k <= r; k++) begin
      mem_rsp_valid = (k == r);
      mem_rdata = (k == r) ? rdata : {$urandom, $urandom};
      #2;
      chk("wait_req", 64'(mem_req_valid), 64'd0);
      chk("wait_stall", 64'(lsu_stall), 64'd1);
      tick();
    end
    exp_fwd = store ? addr : exp_wb;
    for (int k = 0; k <= hold; k++) begin
      ls_hold = (k < hold);
      mem_rsp_valid = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      mem_req_ready = 1'($urandom);
      #2;
      chk("done_stall", 64'(lsu_stall), 64'd0);
      chk("done_req", 64'(mem_req_valid), 64'd0);
      chk("done_wb", ls_wbdata, exp_wb);
      chk("done_fwd", ls_data_forward, exp_fwd);
      tick();
    end
    idle_inputs();
    #2;
    chk("after_stall", 64'(lsu_stall), 64'd0);
    chk("after_wb", ls_wbdata, 64'd0);
  endtask

  initial begin
    logic [63:0] a, sd, rd, exp;
    logic [2:0]  f3;
    logic        ren, wen;
    int          n, lane;
    idle_inputs();
    ls_inst = '0; ls_pc = '0;
    rst = 1;
    tick(); tick();
    rst = 0;
    #2;
    chk("rst_req", 64'(mem_req_valid), 64'd0);
    chk("rst_stall", 64'(lsu_stall), 64'd0);
    chk("rst_wb", ls_wbdata, 64'd0);
    chk("rst_fwd", ls_data_forward, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_mis", 64'(ls_misalign), 64'd0);
    tick();

    // directed cases
    run_txn(1, 0, 3'b000, 64'h8000_0003, 64'd0, 64'h1122_3344_8566_7788, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF85);
    run_txn(1, 0, 3'b110, 64'h8000_0004, 64'd0, 64'h1122_3344_8566_7788, 0, 0, 0, 64'h0000_0000_1122_3344);
    run_txn(0, 1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 3, 0, 0, 64'd0);
    chk("sh_strb_model", 64'(m_strb(3'b001, 6)), 64'h0000_0000_0000_00C0);
    run_txn(1, 0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 0, 64'd0);
    run_txn(1, 0, 3'b011, 64'h8000_0010, 64'd0, 64'hDEAD_BEEF_0123_4567, 1, 1, 2, 64'hDEAD_BEEF_0123_4567);
    run_txn(1, 1, 3'b011, 64'h8000_0018, 64'h55AA_55AA_55AA_55AA, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'd0);

    // reset during WAIT, then a stale response
    ls_valid = 1; ls_mem_ren = 1; ls_funct3 = 3'b011; ls_exu_res = 64'h8000_0020; ls_wbctl = 2'b01;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    mem_rsp_valid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    #2;
    chk("rstw_stall", 64'(lsu_stall), 64'd0);
    chk("rstw_req", 64'(mem_req_valid), 64'd0);
    chk("rstw_wb", ls_wbdata, 64'd0);
    chk("rstw_fwd", ls_data_forward, 64'd0);
    tick();
    mem_rsp_valid = 0;
    #2;
    chk("rstw_wb2", ls_wbdata, 64'd0);
    chk("rstw_stall2", 64'(lsu_stall), 64'd0);
    tick();
    run_txn(1, 0, 3'b100, 64'h8000_0021, 64'd0, 64'h0000_0000_0000_F000, 0, 0, 0, 64'h0000_0000_0000_00F0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      f3   = 3'($urandom);
      n    = nbytes(f3);
      lane = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) lane = (lane / n) * n;
      a    = 64'h8000_0000 + 64'({$urandom_range(0, 255), 3'b000}) + 64'(lane);
      wen  = 1'($urandom);
      ren  = wen ? 1'($urandom) : 1'b1;
      sd   = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      exp  = wen ? 64'd0 : m_load(rd, lane, f3);
      run_txn(ren, wen, f3, a, sd, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), exp);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
